// File: rtl/mux_reg_n.sv
// mux_reg_n: registered N-way selector with a one-entry valid/ready output stage.
// One of NUM_IN sources is captured into a holding register with the select code
// that chose it. The value stays stable until the consumer accepts it.
// An out-of-range select captures zero and raises a sticky error flag.
`timescale 1ns/1ps

module mux_reg_n #(
  parameter int              WIDTH     = 32,
  parameter int              NUM_IN    = 4,
  parameter int              SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr,
  output logic [15:0]             xfer_cnt
);

  // One extra bit so that NUM_IN == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NumInW = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic             capture;

  // The stage is free when empty or being drained; reset keeps it open.
  assign in_ready = rst || !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !rst;
  assign sel_oob  = ({1'b0, sel} >= NumInW);

  // Source selection; an out-of-range select matches no source and yields zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: capture (possibly replacing a draining value), else drain; errors beat err_clr.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (capture) begin
      data_d  = sel_data;
      sel_d   = sel;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 16'd1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (capture && sel_oob) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any held value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RESET_VAL;
      sel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_reg_n.sv
// tb_mux_reg_n: scoreboard bench for two mux_reg_n instances sharing stimulus.
// Instance 0 has four sources and a zero reset value; instance 1 has three
// sources and a non-zero reset value, so select 3 is out of range there.
`timescale 1ns/1ps

module tb_mux_reg_n;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [127:0] din;
  logic [1:0]   sel;
  logic         inValid;
  logic         outReady;
  logic         errClr;

  logic         inReady  [2];
  logic [31:0]  outData  [2];
  logic [1:0]   outSel   [2];
  logic         outValid [2];
  logic         selErr   [2];
  logic [15:0]  xferCnt  [2];

  int           numIn    [2] = '{4, 3};
  logic [31:0]  resetVal [2] = '{32'h0000_0000, 32'h1234_5678};

  bit           mValid;
  logic [31:0]  mData [2];
  logic [1:0]   mSel  [2];
  logic [15:0]  mCnt  [2];
  bit           mErr  [2];

  exp_t         q0[$];
  exp_t         q1[$];

  int           nCompared   = 0;
  int           nMismatched = 0;

  logic [31:0]  pattern [4] = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};

  mux_reg_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .RESET_VAL(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .in_valid(inValid),
    .in_ready(inReady[0]), .out_data(outData[0]), .out_sel(outSel[0]),
    .out_valid(outValid[0]), .out_ready(outReady), .sel_err(selErr[0]),
    .err_clr(errClr), .xfer_cnt(xferCnt[0])
  );

  mux_reg_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .RESET_VAL(32'h1234_5678)) dut1 (
    .clk(clk), .rst(rst), .din(din[95:0]), .sel(sel), .in_valid(inValid),
    .in_ready(inReady[1]), .out_data(outData[1]), .out_sel(outSel[1]),
    .out_valid(outValid[1]), .out_ready(outReady), .sel_err(selErr[1]),
    .err_clr(errClr), .xfer_cnt(xferCnt[1])
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run can never hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, update the reference, check after the rising edge
  task automatic applyStimulus(input bit rstV, input bit validV, input logic [1:0] selV,
                               input bit readyV, input bit clrV);
    bit          expReady;
    bit          capNow;
    bit          oob;
    logic [31:0] word;
    exp_t        e;
    rst      = rstV;
    inValid  = validV;
    sel      = selV;
    outReady = readyV;
    errClr   = clrV;
    #1;
    expReady = rstV || !mValid || readyV;
    for (int i = 0; i < 2; i++) checkOutput($sformatf("in_ready[%0d]", i), 32'(inReady[i]), 32'(expReady));
    capNow = !rstV && validV && expReady;
    for (int i = 0; i < 2; i++) begin
      if (rstV) begin
        mData[i] = resetVal[i];
        mSel[i]  = 2'd0;
        mCnt[i]  = 16'd0;
        mErr[i]  = 1'b0;
      end else begin
        oob = (int'(selV) >= numIn[i]);
        if (capNow) begin
          word     = oob ? 32'd0 : din[int'(selV)*32 +: 32];
          mData[i] = word;
          mSel[i]  = selV;
          mCnt[i]  = mCnt[i] + 16'd1;
          e.data   = word;
          e.sel    = selV;
          e.cnt    = mCnt[i];
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        if (capNow && oob)  mErr[i] = 1'b1;
        else if (clrV)      mErr[i] = 1'b0;
      end
    end
    if (rstV)        mValid = 1'b0;
    else if (capNow) mValid = 1'b1;
    else if (readyV) mValid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("out_valid[%0d]", i), 32'(outValid[i]), 32'(mValid));
      checkOutput($sformatf("sel_err[%0d]", i), 32'(selErr[i]), 32'(mErr[i]));
      checkOutput($sformatf("xfer_cnt[%0d]", i), 32'(xferCnt[i]), 32'(mCnt[i]));
    end
    @(negedge clk);
  endtask

  // Monitor: whenever a DUT accepts a capture, pop the expected result and compare the presented output
  initial begin
    bit   acc [2];
    exp_t e;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) acc[i] = inValid && inReady[i] && !rst;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_capture[%0d]: got a capture expected none at %0t", i, $time);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("sb_data[%0d]", i), outData[i], e.data);
            checkOutput($sformatf("sb_sel[%0d]", i), 32'(outSel[i]), 32'(e.sel));
            checkOutput($sformatf("sb_cnt[%0d]", i), 32'(xferCnt[i]), 32'(e.cnt));
          end
        end
      end
    end
  end

  task automatic loadPattern();
    din = {pattern[3], pattern[2], pattern[1], pattern[0]};
  endtask

  // Directed test plan followed by random traffic, reset mid-operation and counter wrap
  initial begin
    rst = 1'b1; inValid = 1'b0; sel = 2'd0; outReady = 1'b0; errClr = 1'b0;
    mValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mData[i] = resetVal[i]; mSel[i] = 2'd0; mCnt[i] = 16'd0; mErr[i] = 1'b0;
    end
    loadPattern();
    @(negedge clk);

    // Reset for two cycles with in_valid high, which must be ignored
    applyStimulus(1, 1, 2'd2, 0, 0);
    applyStimulus(1, 1, 2'd2, 0, 0);
    checkOutput("reset_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset_data0", outData[0], 32'h0000_0000);
    checkOutput("reset_data1", outData[1], 32'h1234_5678);
    checkOutput("reset_cnt", 32'(xferCnt[0]), 32'd0);

    // First capture of source 2
    applyStimulus(0, 1, 2'd2, 0, 0);
    checkOutput("first_data", outData[0], 32'hCCCC0002);
    checkOutput("first_sel", 32'(outSel[0]), 32'd2);
    checkOutput("first_valid", 32'(outValid[0]), 32'd1);
    checkOutput("first_cnt", 32'(xferCnt[0]), 32'd1);

    // Backpressure: din and sel churn but nothing moves
    for (int c = 0; c < 5; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(0, 1, 2'd0, 0, 0);
      checkOutput("hold_data", outData[0], 32'hCCCC0002);
      checkOutput("hold_sel", 32'(outSel[0]), 32'd2);
      checkOutput("hold_cnt", 32'(xferCnt[0]), 32'd1);
    end
    loadPattern();

    // Streaming at full rate
    for (int s = 0; s < 4; s++) begin
      applyStimulus(0, 1, 2'(s), 1, 0);
      checkOutput("stream_data", outData[0], pattern[s]);
    end
    checkOutput("stream_cnt", 32'(xferCnt[0]), 32'd5);
    checkOutput("oob_data", outData[1], 32'd0);
    checkOutput("oob_err1", 32'(selErr[1]), 32'd1);
    checkOutput("oob_err0", 32'(selErr[0]), 32'd0);

    // err_clr alone clears, err_clr with an error capture keeps the flag
    applyStimulus(0, 0, 2'd3, 1, 1);
    checkOutput("clr_alone", 32'(selErr[1]), 32'd0);
    applyStimulus(0, 1, 2'd3, 1, 1);
    checkOutput("clr_vs_err", 32'(selErr[1]), 32'd1);
    applyStimulus(0, 0, 2'd0, 1, 0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end

    // Reset while a value is held and unconsumed
    loadPattern();
    applyStimulus(1, 0, 2'd0, 0, 0);
    applyStimulus(0, 1, 2'd1, 0, 0);
    checkOutput("held_valid", 32'(outValid[0]), 32'd1);
    applyStimulus(1, 1, 2'd2, 0, 1);
    checkOutput("midrst_valid", 32'(outValid[0]), 32'd0);
    checkOutput("midrst_data0", outData[0], 32'h0000_0000);
    checkOutput("midrst_data1", outData[1], 32'h1234_5678);

    // Counter wrap
    for (int c = 0; c < 65535; c++) applyStimulus(0, 1, 2'($urandom_range(0, 3)), 1, 0);
    checkOutput("cnt_full", 32'(xferCnt[0]), 32'h0000_FFFF);
    applyStimulus(0, 1, 2'd0, 1, 0);
    checkOutput("cnt_wrap", 32'(xferCnt[0]), 32'h0000_0000);

    applyStimulus(0, 0, 2'd0, 1, 0);
    checkOutput("sb_left0", q0.size(), 32'd0);
    checkOutput("sb_left1", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
